confronto_seriale: RTL and testbench
====================================

# confronto_seriale

Multi-cycle parametrised magnitude comparator: the successor to the 2-bit combinational "greater-than" block. Compares two N-bit operands MSB-first, W bits per clock. It supports unsigned and two's-complement modes, exits early on the first differing chunk, and reports the full gt/eq/lt relation. It sits behind a start/done handshake so datapaths can share one comparator across sequenced operations.

## Interface
Parameters:
- N, 8, operand width in bits; N ≥ 2.
- W, 2, bits compared per cycle; 1 ≤ W ≤ N; N must be a multiple of W. C = N/W chunks.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- x  input  N  left operand; sampled with start.
- y  input  N  right operand; sampled with start.
- ready  output  1  1 when idle and able to accept start.
- done  output  1  one-cycle pulse: result valid.
- gt  output  1  x > y.
- eq  output  1  x == y.
- lt  output  1  x < y.

## Operation
- States: IDLE, RUN, DONE. ready = (state == IDLE), driven combinationally from state.
- IDLE, start=1:
  - Latch xr = x and yr = y. If signed_mode=1, invert bit N-1 of both latched copies; this maps two's complement onto offset binary, so every later compare is unsigned.
  - Set chunk index k = C-1.
  - Clear gt, eq, lt to 0.
  - Go to RUN.
- IDLE, start=0: hold.
- RUN, each cycle, compare chunk k (bits [k*W+W-1 : k*W]) of xr and yr as unsigned values:
  - xr chunk > yr chunk: gt←1, go to DONE.
  - xr chunk < yr chunk: lt←1, go to DONE.
  - Equal and k=0: eq←1, go to DONE.
  - Equal and k>0: k←k-1, stay in RUN.
- DONE: done=1 for this single cycle, then go to IDLE unconditionally.
- Exactly one of gt/eq/lt is 1 after any completed compare.
- Results hold from DONE until the next accepted start clears them.
- start is ignored while in RUN or DONE; no queuing.
- x, y and signed_mode may change freely after acceptance; only the latched copies are used.
- Index register is max(1, clog2(C)) bits wide. When C=1, RUN always takes the k=0 decision path.

## Timing
- Reset (reset_n=0 at a rising edge) gives: state=IDLE, ready=1, done=0, gt=0, eq=0, lt=0, k=0. Latched operands are don't-care.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, all results 0, ready=1 in the cycle after the reset edge.
- Reset has priority over start in the same cycle.
- Start accepted at edge E0. Chunk i (i=1 is the MSB chunk) is decided at edge E0+i. done=1 and results are valid in the cycle following the deciding edge.
- Latency: m cycles from acceptance to done, where m is the number of chunks examined (1 ≤ m ≤ C). Equality always takes C cycles.
- ready returns to 1 one cycle after the done cycle, so the minimum start-to-start spacing is m+1 cycles.
- gt/eq/lt are registered outputs with no combinational path from x/y.

## Test plan
All scenarios use N=8, W=2 unless stated.
- Reset: hold reset_n=0 for 2 cycles with start=1 -> ready=1, done=0, gt=eq=lt=0, and no operation accepted.
- Early exit, unsigned: x=0xA5, y=0x5A, signed_mode=0 -> done in the 1st cycle after acceptance, gt=1, eq=0, lt=0.
- Full-length cases, unsigned:
  - x=0x3C, y=0x3C -> done after 4 cycles, eq=1.
  - x=0x34, y=0x35 -> done after 4 cycles, lt=1.
- Signed vs unsigned: x=0x80, y=0x7F.
  - signed_mode=1 -> lt=1 after 1 cycle.
  - Same operands, signed_mode=0 -> gt=1.
  - x=0xFF, y=0xFE, signed_mode=1 -> gt=1 after 4 cycles.
- Handshake: start held high continuously with changing x/y -> new compares accepted only in cycles where ready=1. Results match the operands present at acceptance, and done pulses exactly once per accepted start.
- Reset mid-run and degenerate configuration:
  - x=0x01, y=0x00, reset_n=0 in the 2nd RUN cycle -> no done, outputs 0, ready=1 next cycle.
  - Parameters N=8, W=8 -> every compare completes in 1 cycle.

Source files
------------

// File: rtl/confronto_seriale.sv
// confronto_seriale: MSB-first N-bit magnitude comparator, W bits per cycle, unsigned or two's-complement.
// Latency: m cycles from accepted start to the done pulse (m = chunks examined, 1..N/W; equality takes N/W).
// Backpressure: ready is low while busy; start is ignored then and never queued.
module confronto_seriale #(
   parameter int N = 8,
   parameter int W = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic         signed_mode,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic         ready,
   output logic         done,
   output logic         gt,
   output logic         eq,
   output logic         lt
);
   localparam int C  = N / W;
   localparam int KW = (C > 1) ? $clog2(C) : 1;
   localparam logic [KW-1:0] K_TOP = KW'(C - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q;
   logic [N-1:0]   xr_q, yr_q;
   logic [N-1:0]   x_d, y_d;
   logic [KW-1:0]  k_q;
   logic           done_q, gt_q, eq_q, lt_q;
   logic [W-1:0]   xc, yc;

   // Flipping the sign bit maps two's complement onto offset binary, so the chunk walk stays unsigned.
   always_comb begin
      x_d = x;
      y_d = y;
      if (signed_mode) begin
         x_d[N-1] = ~x[N-1];
         y_d[N-1] = ~y[N-1];
      end
   end

   // Chunk currently under examination; with a single chunk k_q stays at zero.
   assign xc = xr_q[int'(k_q) * W +: W];
   assign yc = yr_q[int'(k_q) * W +: W];

   // Control FSM: latch operands, walk chunks MSB-first, stop on first difference, pulse done once.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         xr_q    <= '0;
         yr_q    <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  xr_q    <= x_d;
                  yr_q    <= y_d;
                  k_q     <= K_TOP;
                  gt_q    <= 1'b0;
                  eq_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (xc > yc) begin
                  gt_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (xc < yc) begin
                  lt_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (k_q == '0) begin
                  eq_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q - KW'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = (state_q == S_IDLE);
   assign done  = done_q;
   assign gt    = gt_q;
   assign eq    = eq_q;
   assign lt    = lt_q;

endmodule

// File: tb/tb_confronto_seriale.sv
// Bench for confronto_seriale: two instances (W=2 and W=8) share one stimulus stream.
// A behavioural model predicts result, latency and ready per instance; a monitor pops on done.
module tb_confronto_seriale;
   logic       clock;
   logic       reset_n, start, signed_mode;
   logic [7:0] x, y;
   logic       ready2, done2, gt2, eq2, lt2;
   logic       ready8, done8, gt8, eq8, lt8;

   confronto_seriale #(.N(8), .W(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
      .x(x), .y(y), .ready(ready2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2)
   );

   confronto_seriale #(.N(8), .W(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
      .x(x), .y(y), .ready(ready8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] r;
      int         due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic chk_en = 1'b0;

   logic       exp_ready [2];
   logic [2:0] exp_res   [2];
   logic [2:0] busy_res  [2];
   logic       busy      [2];
   int         due       [2];

   localparam logic [7:0] DA [6] = '{8'hA5, 8'h3C, 8'h34, 8'h80, 8'h80, 8'hFF};
   localparam logic [7:0] DB [6] = '{8'h5A, 8'h3C, 8'h35, 8'h7F, 8'h7F, 8'hFE};
   localparam logic       DS [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   // Result {gt,eq,lt} from plain integer comparison.
   function automatic logic [2:0] ref_res(input logic [7:0] a, input logic [7:0] b, input logic sm);
      int ia, ib;
      if (sm) begin
         ia = $signed(a);
         ib = $signed(b);
      end else begin
         ia = int'(a);
         ib = int'(b);
      end
      if (ia > ib) return 3'b100;
      if (ia == ib) return 3'b010;
      return 3'b001;
   endfunction

   // Chunks examined: up to and including the chunk holding the highest differing bit.
   function automatic int ref_len(input logic [7:0] a, input logic [7:0] b, input int wc);
      int c;
      c = 8 / wc;
      for (int i = 7; i >= 0; i--) begin
         if (a[i] != b[i]) return c - i / wc;
      end
      return c;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, expv);
      end
   endtask

   // Reference model: advances at each clock edge and predicts the cycle that follows.
   always @(posedge clock) begin
      exp_t e;
      int   m;
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) begin
            exp_ready[d] = 1'b1;
            exp_res[d]   = 3'b000;
            busy[d]      = 1'b0;
            if (d == 0) q0.delete(); else q1.delete();
         end else if (exp_ready[d] && start) begin
            m            = ref_len(x, y, (d == 0) ? 2 : 8);
            busy_res[d]  = ref_res(x, y, signed_mode);
            due[d]       = cyc + m;
            busy[d]      = 1'b1;
            exp_ready[d] = 1'b0;
            exp_res[d]   = 3'b000;
            e.r          = busy_res[d];
            e.due        = due[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
         end else if (busy[d] && cyc == due[d]) begin
            exp_res[d] = busy_res[d];
         end else if (busy[d] && cyc == due[d] + 1) begin
            busy[d]      = 1'b0;
            exp_ready[d] = 1'b1;
         end
      end
   end

   task automatic mon(input int d, input logic rdy, input logic dn, input logic [2:0] o);
      exp_t e;
      int   sz;
      chk("ready", d, 32'(rdy), 32'(exp_ready[d]));
      chk("gt_eq_lt", d, 32'(o), 32'(exp_res[d]));
      sz = (d == 0) ? q0.size() : q1.size();
      if (dn === 1'b1) begin
         checks++;
         if (sz == 0) begin
            errors++;
            $display("FAIL done_unexpected dut%0d cyc=%0d got=1 want=0", d, cyc);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("result", d, 32'(o), 32'(e.r));
            chk("latency", d, cyc, e.due);
         end
      end else if (sz > 0) begin
         e = (d == 0) ? q0[0] : q1[0];
         if (cyc > e.due) begin
            checks++;
            errors++;
            $display("FAIL done_missing dut%0d cyc=%0d got=0 want=1_at_%0d", d, cyc, e.due);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
      end
   endtask

   // Monitor: samples both instances mid-cycle.
   always @(negedge clock) begin
      if (chk_en) begin
         mon(0, ready2, done2, {gt2, eq2, lt2});
         mon(1, ready8, done8, {gt8, eq8, lt8});
      end
   end

   task automatic rand_pair(output logic [7:0] a, output logic [7:0] b);
      a = 8'($urandom);
      case ($urandom_range(0, 2))
         0:       b = 8'($urandom);
         1:       b = a ^ (8'h01 << $urandom_range(0, 7));
         default: b = a;
      endcase
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(ready2 && ready8) && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_ready cyc=%0d got=busy want=ready", cyc);
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm);
      logic [7:0] ra, rb;
      wait_idle();
      x           = a;
      y           = b;
      signed_mode = sm;
      start       = 1'b1;
      @(negedge clock);
      start = 1'b0;
      rand_pair(ra, rb);
      x           = ra;
      y           = rb;
      signed_mode = ~sm;
   endtask

   initial begin
      logic [7:0] ra, rb;
      reset_n     = 1'b0;
      start       = 1'b1;
      signed_mode = 1'b0;
      x           = 8'($urandom);
      y           = 8'($urandom);
      @(negedge clock);
      chk_en = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      start   = 1'b0;
      repeat (2) @(negedge clock);

      // Directed vectors: early exit, full length, signed vs unsigned.
      for (int i = 0; i < 6; i++) issue(DA[i], DB[i], DS[i]);
      wait_idle();

      // start held high while operands change every cycle.
      start = 1'b1;
      repeat (200) begin
         rand_pair(ra, rb);
         x           = ra;
         y           = rb;
         signed_mode = 1'($urandom);
         @(negedge clock);
      end
      start = 1'b0;
      wait_idle();

      // Reset in the second RUN cycle of a full-length compare.
      issue(8'h01, 8'h00, 1'b0);
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Random operations with random gaps and occasional resets.
      repeat (300) begin
         rand_pair(ra, rb);
         issue(ra, rb, 1'($urandom));
         repeat ($urandom_range(0, 5)) @(negedge clock);
         if ($urandom_range(0, 29) == 0) begin
            reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
         end
      end

      repeat (20) @(negedge clock);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d,%0d want=0,0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
